// File: rtl/res_writer.sv
// Result writer: de-skews diagonal systolic-array column outputs into aligned rows,
// optionally applies ReLU, and writes each row across NB banks of one ping-pong side.
module res_writer #(
   parameter int COL_NUM     = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int BANK_WIDTH  = 128,
   parameter int NB          = COL_NUM*DATA_WIDTH/BANK_WIDTH,
   parameter int ADDR_W      = 15,
   parameter int ROW_W       = 11,
   parameter int ADDR_STRIDE = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           cfg_pingpang,
   input  logic [ADDR_W-1:0]              cfg_base,
   input  logic [ROW_W-1:0]               cfg_rows,
   input  logic                           cfg_relu,
   input  logic [COL_NUM*DATA_WIDTH-1:0]  array_data_in,
   input  logic                           array_valid_in,
   output logic [2*NB-1:0]                bce,
   output logic [2*NB*ADDR_W-1:0]         bwaddr,
   output logic [2*NB*BANK_WIDTH-1:0]     bwdata,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);

   localparam int ROW_BITS = COL_NUM*DATA_WIDTH;
   localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                  r_state;
   state_t                  w_state_nx;

   logic                    r_pp;
   logic                    r_relu;
   logic [ADDR_W-1:0]       r_base;
   logic [ROW_W-1:0]        r_rows;
   logic [ROW_W-1:0]        r_row_cnt;
   logic [ROW_W-1:0]        w_cnt_nx;

   logic [COL_NUM-2:0]      r_vpipe;
   logic [COL_NUM-1:0]      w_vcat;
   logic [ROW_BITS-1:0]     w_aligned;
   logic [ROW_BITS-1:0]     r_al_data;
   logic                    r_al_valid;
   logic [ROW_BITS-1:0]     w_row;

   logic                    w_eff_pp;
   logic                    w_eff_relu;
   logic [ADDR_W-1:0]       w_eff_base;
   logic [ROW_W-1:0]        w_eff_rows;
   logic [ROW_W-1:0]        w_eff_cnt;
   logic                    w_eff_run;
   logic                    w_write;
   logic                    w_last;
   logic [ADDR_W-1:0]       w_addr;

   logic [2*NB-1:0]         w_bce_nx;
   logic                    w_done_nx;
   logic                    w_err_nx;

   logic [2*NB-1:0]         r_bce;
   logic [2*NB*ADDR_W-1:0]  r_bwaddr;
   logic [2*NB*BANK_WIDTH-1:0] r_bwdata;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;

   // Column i lags column 0 by i cycles, so it is delayed COL_NUM-1-i stages to line up.
   genvar gi;
   generate
      for (gi = 0; gi < COL_NUM; gi++) begin : g_col
         if (gi == COL_NUM-1) begin : g_thru
            assign w_aligned[gi*DATA_WIDTH +: DATA_WIDTH] = array_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
         end else begin : g_sr
            localparam int DEPTH = COL_NUM-1-gi;
            logic [DATA_WIDTH-1:0] r_sr [DEPTH];

            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  for (int j = 0; j < DEPTH; j++) r_sr[j] <= '0;
               end else begin
                  r_sr[0] <= array_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
                  for (int j = 1; j < DEPTH; j++) r_sr[j] <= r_sr[j-1];
               end
            end

            assign w_aligned[gi*DATA_WIDTH +: DATA_WIDTH] = r_sr[DEPTH-1];
         end
      end
   endgenerate

   assign w_vcat = {r_vpipe, array_valid_in};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vpipe    <= '0;
         r_al_data  <= '0;
         r_al_valid <= 1'b0;
      end else begin
         r_vpipe    <= w_vcat[COL_NUM-2:0];
         r_al_data  <= w_aligned;
         r_al_valid <= r_vpipe[COL_NUM-2];
      end
   end

   // A start in the same cycle as an aligned row takes effect first, so the row
   // sees the incoming configuration rather than the latched one.
   assign w_eff_pp   = start ? cfg_pingpang : r_pp;
   assign w_eff_relu = start ? cfg_relu     : r_relu;
   assign w_eff_base = start ? cfg_base     : r_base;
   assign w_eff_rows = start ? cfg_rows     : r_rows;
   assign w_eff_cnt  = start ? '0           : r_row_cnt;
   assign w_eff_run  = start ? (cfg_rows != '0) : (r_state == S_RUN);
   assign w_write    = w_eff_run & r_al_valid;
   assign w_last     = w_write & (w_eff_cnt == (w_eff_rows - ROW_ONE));
   assign w_addr     = ADDR_W'(32'(w_eff_base) + 32'(w_eff_cnt) * 32'(ADDR_STRIDE));

   always_comb begin
      w_row = r_al_data;
      for (int c = 0; c < COL_NUM; c++) begin
         if (w_eff_relu && r_al_data[c*DATA_WIDTH + DATA_WIDTH-1]) begin
            w_row[c*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_row_cnt;
      w_bce_nx   = '0;
      w_done_nx  = 1'b0;
      w_err_nx   = r_err;

      if (w_eff_run && !w_last) w_state_nx = S_RUN;
      else                      w_state_nx = S_IDLE;

      if (start) begin
         w_cnt_nx = '0;
         w_err_nx = 1'b0;
         if (cfg_rows == '0) w_done_nx = 1'b1;
      end

      if (w_write) begin
         w_cnt_nx = w_eff_cnt + ROW_ONE;
         for (int k = 0; k < NB; k++) begin
            if (w_eff_pp) w_bce_nx[NB + k] = 1'b1;
            else          w_bce_nx[k]      = 1'b1;
         end
         if (w_last) w_done_nx = 1'b1;
      end else if (r_al_valid && !start) begin
         w_err_nx = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_row_cnt <= '0;
         r_pp      <= 1'b0;
         r_relu    <= 1'b0;
         r_base    <= '0;
         r_rows    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_row_cnt <= w_cnt_nx;
         r_busy    <= w_eff_run;
         r_done    <= w_done_nx;
         r_err     <= w_err_nx;
         if (start) begin
            r_pp   <= cfg_pingpang;
            r_relu <= cfg_relu;
            r_base <= cfg_base;
            r_rows <= cfg_rows;
         end
      end
   end

   // Address/data slices of banks that are not written keep their last value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bce    <= '0;
         r_bwaddr <= '0;
         r_bwdata <= '0;
      end else begin
         r_bce <= w_bce_nx;
         for (int b = 0; b < 2*NB; b++) begin
            if (w_bce_nx[b]) begin
               r_bwaddr[b*ADDR_W +: ADDR_W]         <= w_addr;
               r_bwdata[b*BANK_WIDTH +: BANK_WIDTH] <= w_row[(b % NB)*BANK_WIDTH +: BANK_WIDTH];
            end
         end
      end
   end

   assign bce    = r_bce;
   assign bwaddr = r_bwaddr;
   assign bwdata = r_bwdata;
   assign busy   = r_busy;
   assign done   = r_done;
   assign err    = r_err;

endmodule

// File: tb/tb_res_writer.sv
// Bench for res_writer: directed and random rows checked every cycle against a
// row-level reference model (valid at edge k lands as a write at edge k+COL_NUM).
module tb_res_writer;

  localparam int COL  = 32;
  localparam int DW   = 16;
  localparam int BW   = 128;
  localparam int NB   = COL*DW/BW;
  localparam int AW   = 15;
  localparam int RW   = 11;
  localparam int STR  = 16;
  localparam int RB   = COL*DW;
  localparam int NCYC = 2048;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cfg_pingpang = 1'b0;
  logic [AW-1:0]     cfg_base = '0;
  logic [RW-1:0]     cfg_rows = '0;
  logic              cfg_relu = 1'b0;
  logic [RB-1:0]     array_data_in = '0;
  logic              array_valid_in = 1'b0;
  logic [2*NB-1:0]   bce;
  logic [2*NB*AW-1:0] bwaddr;
  logic [2*NB*BW-1:0] bwdata;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  res_writer #(
    .COL_NUM(COL), .DATA_WIDTH(DW), .BANK_WIDTH(BW), .NB(NB),
    .ADDR_W(AW), .ROW_W(RW), .ADDR_STRIDE(STR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_pingpang(cfg_pingpang),
    .cfg_base(cfg_base), .cfg_rows(cfg_rows), .cfg_relu(cfg_relu),
    .array_data_in(array_data_in), .array_valid_in(array_valid_in),
    .bce(bce), .bwaddr(bwaddr), .bwdata(bwdata),
    .busy(busy), .done(done), .err(err)
  );

  int errors = 0;
  int checks = 0;

  // injection history: row injected at edge t and its column values
  bit            inj [NCYC];
  logic [DW-1:0] rd  [NCYC][COL];
  logic [DW-1:0] cur_row [COL];
  int            t = 0;
  int            last_rst = -1;

  // reference model state and expected outputs
  bit            m_active, m_pp, m_relu, m_err;
  logic [AW-1:0] m_base;
  int            m_rows, m_cnt;
  logic [2*NB-1:0] e_bce;
  logic [AW-1:0] e_addr [2*NB];
  logic [BW-1:0] e_data [2*NB];
  bit            e_done, e_busy;

  task automatic check(input string tag, input int idx, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] got=%h exp=%h", tag, idx, got, exp);
    end
  endtask

  task automatic model_edge(input bit st, input bit rs);
    int k;
    bit arr;
    logic [RB-1:0] row;
    logic [DW-1:0] val;
    int b;
    e_bce  = '0;
    e_done = 1'b0;
    if (rs) begin
      m_active = 0; m_cnt = 0; m_err = 0; e_busy = 0;
      for (int i = 0; i < 2*NB; i++) begin e_addr[i] = '0; e_data[i] = '0; end
      last_rst = t;
      return;
    end
    k   = t - COL;
    arr = (k >= 0) && inj[k] && (k > last_rst);
    if (st) begin
      m_err = 0;
      if (cfg_rows == 0) begin
        m_active = 0;
        e_done   = 1;
      end else begin
        m_active = 1; m_pp = cfg_pingpang; m_base = cfg_base;
        m_rows = int'(cfg_rows); m_relu = cfg_relu; m_cnt = 0;
      end
    end
    e_busy = m_active;
    if (arr) begin
      if (m_active) begin
        for (int c = 0; c < COL; c++) begin
          val = rd[k][c];
          if (m_relu && $signed(val) < 0) val = '0;
          row[c*DW +: DW] = val;
        end
        for (int j = 0; j < NB; j++) begin
          b = int'(m_pp)*NB + j;
          e_bce[b]  = 1'b1;
          e_addr[b] = AW'((int'(m_base) + m_cnt*STR) % (1 << AW));
          e_data[b] = row[j*BW +: BW];
        end
        m_cnt++;
        if (m_cnt == m_rows) begin
          e_done   = 1;
          m_active = 0;
        end
      end else if (!st) begin
        m_err = 1;
      end
    end
  endtask

  task automatic step(input bit st, input bit v, input bit rs);
    logic [RB-1:0] d;
    int k;
    if (t >= NCYC) begin
      $display("FAIL cycle_budget t=%0d limit=%0d", t, NCYC);
      $fatal(1, "cycle budget exhausted");
    end
    inj[t] = v;
    for (int c = 0; c < COL; c++) rd[t][c] = cur_row[c];
    for (int c = 0; c < COL; c++) begin
      k = t - c;
      if (k >= 0 && inj[k]) d[c*DW +: DW] = rd[k][c];
      else                  d[c*DW +: DW] = DW'($urandom);
    end
    start = st; array_valid_in = v; rst_n = !rs; array_data_in = d;
    @(posedge clk);
    model_edge(st, rs);
    #1;
    check("bce",  0, BW'(bce),  BW'(e_bce));
    check("done", 0, BW'(done), BW'(e_done));
    check("busy", 0, BW'(busy), BW'(e_busy));
    check("err",  0, BW'(err),  BW'(m_err));
    for (int b = 0; b < 2*NB; b++) begin
      check("bwaddr", b, BW'(bwaddr[b*AW +: AW]), BW'(e_addr[b]));
      check("bwdata", b, bwdata[b*BW +: BW], e_data[b]);
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic set_cfg(input bit pp, input logic [AW-1:0] base, input logic [RW-1:0] rows, input bit relu);
    cfg_pingpang = pp; cfg_base = base; cfg_rows = rows; cfg_relu = relu;
  endtask

  task automatic rand_row();
    for (int c = 0; c < COL; c++) cur_row[c] = DW'($urandom);
  endtask

  initial begin
    logic [BW-1:0] exp_bank;
    for (int i = 0; i < NCYC; i++) inj[i] = 0;
    for (int c = 0; c < COL; c++) cur_row[c] = '0;
    for (int i = 0; i < 2*NB; i++) begin e_addr[i] = '0; e_data[i] = '0; end

    // reset
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    idle(2);

    // 4-row frame on side A, column i of row r = r*256+i
    set_cfg(0, 15'h100, 4, 0);
    step(1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < COL; c++) cur_row[c] = DW'(r*256 + c);
      step(0, 1, 0);
    end
    idle(40);
    check("t1_last_addr", 0, BW'(bwaddr[0 +: AW]), BW'(15'h130));
    for (int i = 0; i < 8; i++) exp_bank[i*DW +: DW] = DW'(16'h300 + i);
    check("t1_last_bank0", 0, bwdata[0 +: BW], exp_bank);

    // side B with ReLU on all-negative columns
    set_cfg(1, AW'($urandom), 2, 1);
    step(1, 0, 0);
    for (int c = 0; c < COL; c++) cur_row[c] = 16'h8001;
    step(0, 1, 0);
    step(0, 1, 0);
    idle(36);
    check("t2_sideB_zero", NB, bwdata[NB*BW +: BW], '0);
    check("t2_sideA_addr", 0, BW'(bwaddr[0 +: AW]), BW'(15'h130));

    // address wrap
    set_cfg(0, 15'h7FF0, 3, 1'($urandom));
    step(1, 0, 0);
    for (int r = 0; r < 3; r++) begin rand_row(); step(0, 1, 0); end
    idle(36);
    check("t3_wrap_addr", 0, BW'(bwaddr[0 +: AW]), BW'(15'h0010));

    // stray valid while idle sets err; next start clears it
    rand_row();
    step(0, 1, 0);
    idle(36);
    check("t4_err_set", 0, BW'(err), BW'(1'b1));
    idle(4);
    set_cfg(1'($urandom), AW'($urandom), 2, 1'($urandom));
    step(1, 0, 0);
    check("t4_err_clr", 0, BW'(err), BW'(1'b0));
    for (int r = 0; r < 2; r++) begin rand_row(); step(0, 1, 0); end
    idle(36);

    // zero-row frame: done next cycle, never busy
    set_cfg(0, AW'($urandom), 0, 0);
    step(1, 0, 0);
    check("t5_done", 0, BW'(done), BW'(1'b1));
    check("t5_busy", 0, BW'(busy), BW'(1'b0));
    idle(3);

    // random frames, gaps, restarts and relu
    for (int i = 0; i < 400; i++) begin
      bit st;
      st = ($urandom_range(0, 39) == 0);
      if (st) set_cfg(1'($urandom), AW'($urandom), RW'($urandom_range(0, 6)), 1'($urandom));
      rand_row();
      step(st, 1'($urandom_range(0, 1)), 0);
    end
    idle(40);

    // gapped rows with reset between the first and second write
    set_cfg(0, AW'($urandom), 4, 0);
    step(1, 0, 0);
    rand_row();
    step(0, 1, 0);
    idle(3);
    rand_row();
    step(0, 1, 0);
    idle(29);
    step(0, 0, 1);
    step(0, 0, 1);
    idle(45);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
